// File: rtl/model_block_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// model_block_scheduler_pkg
// Shared types and defaults for the model block scheduler.
//   model_state_t   : model FSM states (IDLE, ACF, SOLVE, READY)
//   release_state_t : release FSM states (WAIT, STREAM)
//   *_DEF           : default parameter values for the scheduler
// -----------------------------------------------------------------------------
package model_block_scheduler_pkg;

    localparam int BLOCK_SIZE_DEF    = 4096;
    localparam int ORDER_DEF         = 12;
    localparam int SOLVE_TIMEOUT_DEF = 2048;

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_ACF   = 2'd1,
        M_SOLVE = 2'd2,
        M_READY = 2'd3
    } model_state_t;

    typedef enum logic {
        R_WAIT   = 1'b0,
        R_STREAM = 1'b1
    } release_state_t;

endpackage

// File: rtl/model_block_scheduler_release_ctrl.sv
// -----------------------------------------------------------------------------
// block_release_ctrl
// Release FSM plus its per-block release counter. Waits until a model is
// ready and at least one full block is buffered, takes the model, then streams
// BLOCK_SIZE read strobes to the buffered sample path.
//
// Ports
//   iClock       : clock
//   iReset       : asynchronous active-low reset
//   iEnable      : global advance qualifier; low holds all state
//   iReady       : downstream can accept a sample this cycle
//   iModelReady  : model FSM is in READY
//   iPendingNz   : at least one fully buffered block exists
//   oRelease     : read strobe, one sample per pulse
//   oBlockStart  : coincident with release index 0
//   oBlockEnd    : coincident with release index BLOCK_SIZE-1
//   oTake        : pulse when the model is consumed (WAIT -> STREAM)
//   oState       : debug view of the release FSM state
//
// Handshake: in STREAM a sample moves on every cycle where iReady and iEnable
// are both high; oRelease is that product, purely combinational, and the
// release counter advances only on those cycles.
// -----------------------------------------------------------------------------
module block_release_ctrl
    import model_block_scheduler_pkg::*;
#(
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF
) (
    input  logic iClock,
    input  logic iReset,
    input  logic iEnable,
    input  logic iReady,
    input  logic iModelReady,
    input  logic iPendingNz,
    output logic oRelease,
    output logic oBlockStart,
    output logic oBlockEnd,
    output logic oTake,
    output logic oState
);

    localparam int CW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_SIZE - 1);

    release_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= R_WAIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        oRelease    = 1'b0;
        oBlockStart = 1'b0;
        oBlockEnd   = 1'b0;
        oTake       = 1'b0;
        case (state_q)
            R_WAIT: begin
                if (iEnable && iModelReady && iPendingNz) begin
                    oTake   = 1'b1;
                    state_d = R_STREAM;
                    cnt_d   = '0;
                end
            end
            R_STREAM: begin
                if (iEnable && iReady) begin
                    oRelease    = 1'b1;
                    oBlockStart = (cnt_q == '0);
                    oBlockEnd   = (cnt_q == LAST_IDX);
                    if (cnt_q == LAST_IDX) begin
                        state_d = R_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = R_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign oState = state_q;

endmodule

// File: rtl/model_block_scheduler.sv
// -----------------------------------------------------------------------------
// model_block_scheduler
// Coordinates sample buffering with LPC model computation. Counts incoming
// samples into blocks (up to two fully buffered blocks pending), tracks the
// model pipeline (ACF collection, solve, ready) and hands a ready model plus a
// buffered block to block_release_ctrl, which streams the samples out.
//
// Optional feature: define MODEL_SCHED_WATCHDOG_EN to add a SOLVE watchdog.
// After SOLVE_TIMEOUT cycles in SOLVE without iModelDone the model FSM moves
// to READY anyway and the sticky oTimeout port marks the model as failed.
// Without the macro there is no watchdog counter and no oTimeout port.
//
// Ports
//   iClock        : clock
//   iReset        : asynchronous active-low reset
//   iEnable       : global advance qualifier; low holds all state
//   iSValid       : one sample entered the delay/FIFO path
//   iACFValid     : one ACF word presented to the divider
//   iModelDone    : quantizer finished the current block's coefficients
//   iReady        : downstream residual stage can accept a sample
//   oRelease      : read strobe for the buffered sample path
//   oBlockStart   : first released sample of a block
//   oBlockEnd     : last released sample of a block
//   oPending      : fully buffered, not yet released blocks (0..2)
//   oBusy         : model FSM not idle
//   oOverflow     : sticky; sample block or ACF word arrived with no room
//   oTimeout      : sticky watchdog flag (watchdog builds only)
//   oModelState   : debug view of the model FSM state
//   oReleaseState : debug view of the release FSM state
// -----------------------------------------------------------------------------
module model_block_scheduler
    import model_block_scheduler_pkg::*;
#(
    parameter int BLOCK_SIZE    = BLOCK_SIZE_DEF,
    parameter int ORDER         = ORDER_DEF,
    parameter int SOLVE_TIMEOUT = SOLVE_TIMEOUT_DEF
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iEnable,
    input  logic       iSValid,
    input  logic       iACFValid,
    input  logic       iModelDone,
    input  logic       iReady,
    output logic       oRelease,
    output logic       oBlockStart,
    output logic       oBlockEnd,
    output logic [1:0] oPending,
    output logic       oBusy,
    output logic       oOverflow,
`ifdef MODEL_SCHED_WATCHDOG_EN
    output logic       oTimeout,
`endif
    output logic [1:0] oModelState,
    output logic       oReleaseState
);

    localparam int SCW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int ACW = (ORDER > 0) ? $clog2(ORDER + 1) : 1;

    // ------------------------------------------------------------------
    // Sample block counter and pending-block bookkeeping
    // ------------------------------------------------------------------
    logic [SCW-1:0] sample_cnt_q;
    logic [1:0]     pending_q;
    logic           overflow_q;
    logic           sample_in;
    logic           block_done;
    logic           rel_end;
    logic           pend_ovf;
    logic           acf_ovf;

    assign sample_in  = iEnable & iSValid;
    assign block_done = sample_in && (sample_cnt_q == SCW'(BLOCK_SIZE - 1));
    // A third block completing with two already pending has nowhere to go,
    // unless the streamed block frees its slot on the same edge.
    assign pend_ovf   = block_done && !rel_end && (pending_q == 2'd2);

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            sample_cnt_q <= '0;
        end else if (sample_in) begin
            sample_cnt_q <= block_done ? '0 : sample_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            pending_q <= 2'd0;
        end else if (block_done && !rel_end) begin
            if (pending_q != 2'd2) begin
                pending_q <= pending_q + 2'd1;
            end
        end else if (rel_end && !block_done) begin
            pending_q <= pending_q - 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Model FSM
    // ------------------------------------------------------------------
    model_state_t   m_state_q, m_state_d;
    logic [ACW-1:0] acf_cnt_q, acf_cnt_d;
    logic           acf_in;
    logic           take;

    assign acf_in  = iEnable & iACFValid;
    assign acf_ovf = acf_in && ((m_state_q == M_SOLVE) || (m_state_q == M_READY));

`ifdef MODEL_SCHED_WATCHDOG_EN
    localparam int WDW = (SOLVE_TIMEOUT > 1) ? $clog2(SOLVE_TIMEOUT) : 1;
    logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
    logic           timeout_q, timeout_d;

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign oTimeout = timeout_q;
`endif

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            m_state_q <= M_IDLE;
            acf_cnt_q <= '0;
        end else begin
            m_state_q <= m_state_d;
            acf_cnt_q <= acf_cnt_d;
        end
    end

    always_comb begin
        m_state_d = m_state_q;
        acf_cnt_d = acf_cnt_q;
`ifdef MODEL_SCHED_WATCHDOG_EN
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
`endif
        case (m_state_q)
            // IDLE and ACF share the word counter: the first word moves to
            // ACF, the (ORDER+1)th word moves on to SOLVE.
            M_IDLE, M_ACF: begin
                if (acf_in) begin
                    if (acf_cnt_q == ACW'(ORDER)) begin
                        m_state_d = M_SOLVE;
                        acf_cnt_d = '0;
`ifdef MODEL_SCHED_WATCHDOG_EN
                        wd_cnt_d  = '0;
`endif
                    end else begin
                        m_state_d = M_ACF;
                        acf_cnt_d = acf_cnt_q + 1'b1;
                    end
                end
            end
            M_SOLVE: begin
                if (iEnable && iModelDone) begin
                    m_state_d = M_READY;
                end
`ifdef MODEL_SCHED_WATCHDOG_EN
                else if (iEnable) begin
                    if (wd_cnt_q == WDW'(SOLVE_TIMEOUT - 1)) begin
                        m_state_d = M_READY;
                        timeout_d = 1'b1;
                    end else begin
                        wd_cnt_d = wd_cnt_q + 1'b1;
                    end
                end
`endif
            end
            M_READY: begin
                if (take) begin
                    m_state_d = M_IDLE;
                end
            end
            default: begin
                m_state_d = M_IDLE;
                acf_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            overflow_q <= 1'b0;
        end else if (pend_ovf || acf_ovf) begin
            overflow_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Release controller
    // ------------------------------------------------------------------
    block_release_ctrl #(
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_release (
        .iClock      (iClock),
        .iReset      (iReset),
        .iEnable     (iEnable),
        .iReady      (iReady),
        .iModelReady (m_state_q == M_READY),
        .iPendingNz  (pending_q != 2'd0),
        .oRelease    (oRelease),
        .oBlockStart (oBlockStart),
        .oBlockEnd   (rel_end),
        .oTake       (take),
        .oState      (oReleaseState)
    );

    assign oBlockEnd   = rel_end;
    assign oPending    = pending_q;
    assign oBusy       = (m_state_q != M_IDLE);
    assign oOverflow   = overflow_q;
    assign oModelState = m_state_q;

endmodule

// File: tb/tb_model_block_scheduler.sv
// -----------------------------------------------------------------------------
// tb_model_block_scheduler
// Self-checking bench for model_block_scheduler with BLOCK_SIZE=16, ORDER=12,
// SOLVE_TIMEOUT=32. Every completed block of driven samples pushes its
// expected release pattern ({start,end} per release) onto exp_q; the monitor
// pops one entry per observed release.
// -----------------------------------------------------------------------------
module tb_model_block_scheduler;
    import model_block_scheduler_pkg::*;

    localparam int BS  = 16;
    localparam int ORD = 12;
    localparam int TO  = 32;

    // ---------------- clock / reset ----------------
    logic iClock = 1'b0;
    logic iReset;
    logic iEnable, iSValid, iACFValid, iModelDone, iReady;
    logic oRelease, oBlockStart, oBlockEnd, oBusy, oOverflow;
    logic [1:0] oPending;
    logic [1:0] oModelState;
    logic oReleaseState;
`ifdef MODEL_SCHED_WATCHDOG_EN
    logic oTimeout;
`endif

    always #5 iClock = ~iClock;

    model_block_scheduler #(
        .BLOCK_SIZE    (BS),
        .ORDER         (ORD),
        .SOLVE_TIMEOUT (TO)
    ) dut (
        .iClock        (iClock),
        .iReset        (iReset),
        .iEnable       (iEnable),
        .iSValid       (iSValid),
        .iACFValid     (iACFValid),
        .iModelDone    (iModelDone),
        .iReady        (iReady),
        .oRelease      (oRelease),
        .oBlockStart   (oBlockStart),
        .oBlockEnd     (oBlockEnd),
        .oPending      (oPending),
        .oBusy         (oBusy),
        .oOverflow     (oOverflow),
`ifdef MODEL_SCHED_WATCHDOG_EN
        .oTimeout      (oTimeout),
`endif
        .oModelState   (oModelState),
        .oReleaseState (oReleaseState)
    );

    // ---------------- scoreboard state ----------------
    int         checks   = 0;
    int         errors   = 0;
    int         rel_seen = 0;
    int         samp_cnt = 0;
    logic [1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge iClock);
        #1;
    endtask

    task automatic push_block();
        exp_q.push_back(2'b10);
        for (int i = 1; i < BS - 1; i++) exp_q.push_back(2'b00);
        exp_q.push_back(2'b01);
    endtask

    task automatic send_samples(input int n);
        for (int i = 0; i < n; i++) begin
            iSValid = 1'b1;
            if (samp_cnt == BS - 1) begin
                samp_cnt = 0;
                push_block();
            end else begin
                samp_cnt++;
            end
            cyc();
        end
        iSValid = 1'b0;
    endtask

    task automatic send_acf(input int n);
        for (int i = 0; i < n; i++) begin
            iACFValid = 1'b1;
            cyc();
        end
        iACFValid = 1'b0;
    endtask

    task automatic pulse_done();
        iModelDone = 1'b1;
        cyc();
        iModelDone = 1'b0;
    endtask

    task automatic do_reset();
        iReset     = 1'b0;
        iEnable    = 1'b1;
        iSValid    = 1'b0;
        iACFValid  = 1'b0;
        iModelDone = 1'b0;
        iReady     = 1'b1;
        #1;
        check("rst_outs", {oRelease, oBlockStart, oBlockEnd, oPending, oBusy, oOverflow}, 0);
`ifdef MODEL_SCHED_WATCHDOG_EN
        check("rst_timeout", oTimeout, 0);
`endif
        exp_q.delete();
        samp_cnt = 0;
        rel_seen = 0;
        cyc();
        cyc();
        iReset = 1'b1;
        cyc();
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) cyc();
        check("drain", exp_q.size(), 0);
        cyc();
        cyc();
    endtask

    // ---------------- monitor ----------------
    always @(negedge iClock) begin : monitor
        logic [1:0] e;
        if (iReset && oRelease) begin
            rel_seen++;
            check("rel_gated", {31'b0, iReady}, 1);
            if (exp_q.size() == 0) begin
                check("rel_unexpected", {31'b0, oRelease}, 0);
            end else begin
                e = exp_q.pop_front();
                check("rel_flags", {30'b0, oBlockStart, oBlockEnd}, {30'b0, e});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        do_reset();

        // iEnable low holds every piece of state
        iEnable = 1'b0;
        iSValid = 1'b1;
        repeat (BS) cyc();
        iSValid   = 1'b0;
        iACFValid = 1'b1;
        cyc();
        iACFValid = 1'b0;
        iEnable   = 1'b1;
        check("en_hold_pend", oPending, 0);
        check("en_hold_busy", oBusy, 0);

        // nominal block
        send_samples(BS);
        check("nom_pend1", oPending, 1);
        send_acf(ORD + 1);
        check("nom_solve", oModelState, M_SOLVE);
        check("nom_busy", oBusy, 1);
        pulse_done();
        check("nom_ready", oModelState, M_READY);
        check("nom_latency", oRelease, 0);
        wait_drain(100);
        check("nom_count", rel_seen, BS);
        check("nom_pend0", oPending, 0);
        check("nom_idle", oBusy, 0);
        check("nom_ovf", oOverflow, 0);

        // back-pressure: iReady pattern 1,0,0,1
        rel_seen = 0;
        send_samples(BS);
        send_acf(ORD + 1);
        pulse_done();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            iReady = ((i % 4) == 0) || ((i % 4) == 3);
            cyc();
        end
        iReady = 1'b1;
        check("bp_drain", exp_q.size(), 0);
        check("bp_count", rel_seen, BS);
        cyc();
        check("bp_pend", oPending, 0);

        // block completion coincident with oBlockEnd, from oPending=1
        do_reset();
        send_samples(BS);
        send_acf(ORD + 1);
        pulse_done();
        for (int i = 0; i < 10 && !oRelease; i++) cyc();
        check("bnd_sync", oRelease, 1);
        send_samples(BS);
        check("bnd_pend", oPending, 1);
        check("bnd_ovf", oOverflow, 0);
        check("bnd_idle", oBusy, 0);
        send_acf(ORD + 1);
        pulse_done();
        wait_drain(100);
        check("bnd_count", rel_seen, 2 * BS);
        check("bnd_pend0", oPending, 0);

        // partial block discarded by reset
        do_reset();
        send_samples(BS / 2);
        do_reset();
        send_samples(BS / 2);
        check("partial_pend", oPending, 0);

        // pending saturation and overflow
        do_reset();
        send_samples(2 * BS);
        check("ovf_pend2", oPending, 2);
        check("ovf_clear", oOverflow, 0);
        send_samples(BS);
        check("ovf_pend_sat", oPending, 2);
        check("ovf_set", oOverflow, 1);

        // ACF word while in SOLVE
        do_reset();
        send_acf(ORD + 1);
        check("acf_solve", oModelState, M_SOLVE);
        check("acf_noovf", oOverflow, 0);
        send_acf(1);
        check("acf_ovf", oOverflow, 1);
        check("acf_stay", oModelState, M_SOLVE);

        // reset after the 8th release
        do_reset();
        send_samples(BS);
        send_acf(ORD + 1);
        pulse_done();
        for (int i = 0; i < 100 && rel_seen < 8; i++) cyc();
        check("mid_at8", rel_seen, 8);
        do_reset();
        send_acf(ORD + 1);
        pulse_done();
        repeat (20) cyc();
        check("mid_norel", rel_seen, 0);
        check("mid_ready", oModelState, M_READY);
        check("mid_pend0", oPending, 0);
        send_samples(BS);
        wait_drain(100);
        check("mid_count", rel_seen, BS);
        check("mid_pend_end", oPending, 0);

`ifdef MODEL_SCHED_WATCHDOG_EN
        // SOLVE watchdog
        do_reset();
        send_samples(BS);
        send_acf(ORD + 1);
        repeat (TO - 1) cyc();
        check("wd_early", oTimeout, 0);
        check("wd_solve", oModelState, M_SOLVE);
        cyc();
        check("wd_fire", oTimeout, 1);
        check("wd_ready", oModelState, M_READY);
        wait_drain(100);
        check("wd_count", rel_seen, BS);
        check("wd_sticky", oTimeout, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/model_block_scheduler.md
MODEL_BLOCK_SCHEDULER -- requirements
Module: model_block_scheduler

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-low.
REQ-002 SHALL provide parameter BLOCK_SIZE, default 4096, meaning samples per block.
REQ-003 SHALL provide parameter ORDER, default 12, meaning the LPC order; ACF words per block equal ORDER+1.
REQ-004 SHALL provide parameter SOLVE_TIMEOUT, default 2048, meaning the maximum number of cycles allowed for solving.
REQ-005 SHALL provide the following ports, listed as name, direction, width, meaning:
- iClock, in, 1, clock.
- iReset, in, 1, asynchronous active-low reset.
- iEnable, in, 1, global advance qualifier; when low, all state holds.
- iSValid, in, 1, one sample entered the delay/FIFO path.
- iACFValid, in, 1, one ACF word was presented to the divider.
- iModelDone, in, 1, the quantizer finished the current block's coefficients.
- iReady, in, 1, the downstream residual stage can accept a sample.
- oRelease, out, 1, read strobe for the buffered sample path (one sample per pulse).
- oBlockStart, out, 1, pulse on the first released sample of a block.
- oBlockEnd, out, 1, pulse on the last released sample of a block.
- oPending, out, 2, count of blocks fully buffered but not yet released (0..2).
- oBusy, out, 1, the model FSM is not idle.
- oOverflow, out, 1, sticky flag: sample arrived while buffer capacity was exhausted.
- oTimeout, out, 1, sticky watchdog flag (present only when the watchdog is configured in).

Function
REQ-006 SHALL count iSValid pulses modulo BLOCK_SIZE; reaching the count BLOCK_SIZE-1 completes a buffered block and increments oPending.
REQ-007 The model FSM SHALL have states IDLE, ACF, SOLVE, READY.
- IDLE→ACF on the first iACFValid.
- ACF→SOLVE after ORDER+1 iACFValid pulses.
- SOLVE→READY on iModelDone.
- READY→IDLE when the release FSM takes the model.
REQ-008 iACFValid received while in SOLVE or READY SHALL be ignored and SHALL set oOverflow.
REQ-009 The release FSM SHALL have states WAIT and STREAM.
- WAIT→STREAM when the model FSM is in READY and oPending>0; this transition consumes the model.
- STREAM→WAIT after BLOCK_SIZE releases.
REQ-010 In STREAM, oRelease SHALL equal iReady combinationally with iEnable; with iReady low, no release occurs and the count holds.
REQ-011 oBlockStart SHALL be high with release index 0; oBlockEnd SHALL be high with release index BLOCK_SIZE-1; both are coincident with oRelease.
REQ-012 oPending SHALL decrement on the oBlockEnd release cycle. Simultaneous block completion and oBlockEnd SHALL leave oPending unchanged.
REQ-013 If a block completes while oPending is 2 and no simultaneous decrement occurs, oPending SHALL saturate at 2 and oOverflow SHALL set.
REQ-014 oBusy SHALL be high in ACF, SOLVE and READY.
REQ-015 Latency: the first oRelease SHALL occur no earlier than 1 cycle after entering READY (registered transition).

Reset
REQ-016 Assertion of iReset (low) SHALL immediately force both FSMs to IDLE/WAIT, clear all counters, and drive every output to 0.
REQ-017 Reset asserted mid-block SHALL discard the partial block; no partial release follows deassertion.
REQ-018 Sticky flags SHALL clear only on reset.

Configuration
REQ-019 Macro MODEL_SCHED_WATCHDOG_EN defined:
- The SOLVE state counts cycles.
- At SOLVE_TIMEOUT cycles without iModelDone, the FSM enters READY, and oTimeout sets sticky.
- The block is released normally; the model is flagged as failed via oTimeout.
REQ-020 Macro MODEL_SCHED_WATCHDOG_EN undefined: there is no counter and no oTimeout port, and SOLVE waits indefinitely.

Structure
REQ-021 A shared package SHALL hold:
- the model-FSM and release-FSM state enumerations;
- default constants BLOCK_SIZE_DEF=4096, ORDER_DEF=12, SOLVE_TIMEOUT_DEF=2048.
REQ-022 The release FSM and its counter SHALL be one sub-module, block_release_ctrl; everything else stays in the top-level module.

Verification
REQ-023 Nominal sequence, BLOCK_SIZE=16, ORDER=12, iReady=1:
- Stimulus: 16 iSValid pulses, 13 iACFValid pulses, iModelDone.
- Response: exactly 16 oRelease pulses, with oBlockStart on the 1st and oBlockEnd on the 16th; oPending goes 1→0; oBusy goes low.
REQ-024 Back-pressure: toggle iReady 1,0,0,1 during STREAM → releases only on iReady=1 cycles; total 16; oBlockEnd still on the 16th release.
REQ-025 Overflow: 48 samples with no iModelDone → oPending saturates at 2 and oOverflow=1 after the 48th sample.
REQ-026 Boundary: block completion coincident with oBlockEnd, starting from oPending=1 → oPending stays 1.
REQ-027 Reset assertion after the 8th release → all outputs 0 immediately; no oRelease until a new complete block plus iModelDone.
REQ-028 With MODEL_SCHED_WATCHDOG_EN and SOLVE_TIMEOUT=32: 13 ACF words and no iModelDone → oTimeout=1 at SOLVE cycle 32, followed by 16 releases.
